// File: rtl/fifoc2cs_multi_if.sv
// Handshake and data bundle between the command parser, the fifoc read
// port and the cs side. The parser connects through the slave modport; the
// environment (cs + fifoc) drives through the master modport.
interface fifoc2cs_multi_if #(
    parameter int NUM_REG = 9
);
    logic                   fs;
    logic                   fd;
    logic                   err;
    logic                   fifoc_empty;
    logic                   fifoc_rxen;
    logic [7:0]             fifoc_rxd;
    logic [NUM_REG*8-1:0]   cmd_regs;
    logic                   cmd_upd;
    logic [7:0]             frame_cnt;

    modport master (
        output fs, fifoc_empty, fifoc_rxd,
        input  fd, err, fifoc_rxen, cmd_regs, cmd_upd, frame_cnt
    );

    modport slave (
        input  fs, fifoc_empty, fifoc_rxd,
        output fd, err, fifoc_rxen, cmd_regs, cmd_upd, frame_cnt
    );
endinterface

// File: rtl/fifoc2cs_multi.sv
// Command-frame parser between fifoc (read side) and cs.
// Frame: HEAD0 HEAD1 data[0..NUM_REG-1] [checksum]. A good frame commits the
// data bytes to cmd_regs in one cycle; a bad header, bad checksum or FIFO
// stall longer than TIMEOUT cycles ends the frame with err=1 and no commit.
// Optional feature macro: CHKSUM_EN adds the trailing checksum byte
// (sum mod 256 of the data bytes).
module fifoc2cs_multi #(
    parameter int          NUM_REG = 9,
    parameter logic [7:0]  HEAD0   = 8'h55,
    parameter logic [7:0]  HEAD1   = 8'hAA,
    parameter int          TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    fifoc2cs_multi_if.slave   bus
);
`ifdef CHKSUM_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif
    localparam int LEN = 2 + NUM_REG + CHK;
    localparam int CW  = $clog2(LEN + 1);
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LEN_C  = CW'(LEN);
    localparam logic [CW-1:0] LAST_C = CW'(LEN - 1);
    localparam logic [CW-1:0] DEND_C = CW'(NUM_REG + 2);
    localparam logic [TW-1:0] TMO_C  = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, READ, COMMIT, DONE} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        iss_q, iss_d, rcv_q, rcv_d;
    logic [TW-1:0]        to_q, to_d;
    logic [7:0]           sum_q, sum_d, cnt_q, cnt_d;
    logic [NUM_REG*8-1:0] shd_q, shd_d, regs_q, regs_d;
    logic                 abort_q, abort_d, err_q, err_d, rd_vld_q;
    logic                 rxen, capt, hdr_bad, last_byte, chk_ok, tmo;

    // Decode of the read request and of the byte arriving this cycle.
    always_comb begin
        rxen      = (state_q == READ) && !bus.fifoc_empty && (iss_q < LEN_C) && !abort_q;
        capt      = rd_vld_q && !abort_q;
        hdr_bad   = capt && (((rcv_q == '0) && (bus.fifoc_rxd != HEAD0)) ||
                             ((rcv_q == CW'(1)) && (bus.fifoc_rxd != HEAD1)));
        last_byte = capt && (rcv_q == LAST_C);
        chk_ok    = (CHK == 0) || (bus.fifoc_rxd == sum_q);
        tmo       = !rxen && (to_q == TMO_C);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state: an aborted frame waits for its in-flight byte to drain.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (bus.fs) state_d = READ;
            READ: begin
                if (hdr_bad)                  state_d = READ;
                else if (abort_q && !rd_vld_q) state_d = DONE;
                else if (last_byte)           state_d = chk_ok ? COMMIT : DONE;
                else if (tmo)                 state_d = DONE;
            end
            COMMIT: state_d = DONE;
            DONE:   if (!bus.fs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Frame datapath: counters, shadow buffer, running sum, commit.
    always_comb begin
        iss_d   = iss_q;
        rcv_d   = rcv_q;
        to_d    = to_q;
        sum_d   = sum_q;
        shd_d   = shd_q;
        abort_d = abort_q;
        err_d   = err_q;
        regs_d  = regs_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE && bus.fs) begin
            iss_d   = '0;
            rcv_d   = '0;
            to_d    = '0;
            sum_d   = '0;
            abort_d = 1'b0;
            err_d   = 1'b0;
        end else if (state_q == READ) begin
            if (rxen) begin
                iss_d = iss_q + CW'(1);
                to_d  = '0;
            end else begin
                to_d  = to_q + TW'(1);
            end
            if (capt) begin
                rcv_d = rcv_q + CW'(1);
                if (rcv_q >= CW'(2) && rcv_q < DEND_C) begin
                    sum_d = sum_q + bus.fifoc_rxd;
                    for (int k = 0; k < NUM_REG; k++)
                        if (rcv_q == CW'(k + 2)) shd_d[k*8 +: 8] = bus.fifoc_rxd;
                end
            end
            if (hdr_bad) abort_d = 1'b1;
            if (state_d == DONE) err_d = 1'b1;
            if (state_d == COMMIT) begin
                regs_d = shd_d;
                cnt_d  = cnt_q + 8'd1;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            iss_q    <= '0;
            rcv_q    <= '0;
            to_q     <= '0;
            sum_q    <= '0;
            shd_q    <= '0;
            abort_q  <= 1'b0;
            err_q    <= 1'b0;
            regs_q   <= '0;
            cnt_q    <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            iss_q    <= iss_d;
            rcv_q    <= rcv_d;
            to_q     <= to_d;
            sum_q    <= sum_d;
            shd_q    <= shd_d;
            abort_q  <= abort_d;
            err_q    <= err_d;
            regs_q   <= regs_d;
            cnt_q    <= cnt_d;
            rd_vld_q <= rxen;
        end
    end

    // Outputs.
    always_comb begin
        bus.fd         = (state_q == DONE);
        bus.err        = err_q;
        bus.fifoc_rxen = rxen;
        bus.cmd_regs   = regs_q;
        bus.cmd_upd    = (state_q == COMMIT);
        bus.frame_cnt  = cnt_q;
    end
endmodule
